// File: rtl/finalsoc_key_ctrl.sv
// Two-key push-button controller: synchroniser, programmable debounce, press capture
// (write-1-to-clear) and maskable level interrupt behind an Avalon-MM slave port.
module finalsoc_key_ctrl #(
    parameter int          DB_W     = 20,
    parameter int unsigned DB_RESET = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [1:0]  in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic [DB_W-1:0] PERIOD_INIT = DB_RESET[DB_W-1:0];

    logic [1:0]      sync1_reg, sync2_reg;
    logic [1:0]      db_reg, db_next;
    logic [1:0]      db_prev_reg;
    logic [DB_W-1:0] period_reg, period_next;
    logic [1:0]      mask_reg, mask_next;
    logic [1:0]      edge_reg, edge_next;
    logic [31:0]     readdata_reg, readdata_next;
    logic            wr_en;
    logic [1:0]      edge_clr;
    logic [1:0]      press;

    assign wr_en = chipselect & ~write_n;

    // Each key debounces independently; >= (not ==) lets a shrunk period
    // release a counter that has already run past the new limit.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic [DB_W-1:0] cnt_reg, cnt_next;
            logic            db_bit_next;

            always_comb begin
                cnt_next    = cnt_reg;
                db_bit_next = db_reg[gi];
                if (sync2_reg[gi] == db_reg[gi]) begin
                    cnt_next = '0;
                end else if (cnt_reg >= period_reg) begin
                    db_bit_next = sync2_reg[gi];
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) cnt_reg <= '0;
                else       cnt_reg <= cnt_next;
            end

            assign db_next[gi] = db_bit_next;
        end
    endgenerate

    assign press    = db_prev_reg & ~db_reg;
    assign edge_clr = (wr_en && address == 2'd3) ? writedata[1:0] : 2'b00;

    always_comb begin
        period_next = period_reg;
        mask_next   = mask_reg;
        if (wr_en && address == 2'd1) period_next = writedata[DB_W-1:0];
        if (wr_en && address == 2'd2) mask_next   = writedata[1:0];
        // A press landing with a clear keeps the bit set.
        edge_next = (edge_reg & ~edge_clr) | press;
    end

    always_comb begin
        readdata_next = 32'd0;
        if (chipselect) begin
            case (address)
                2'd0:    readdata_next = {30'd0, db_reg};
                2'd1:    readdata_next = {{(32-DB_W){1'b0}}, period_reg};
                2'd2:    readdata_next = {30'd0, mask_reg};
                default: readdata_next = {30'd0, edge_reg};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg    <= 2'b11;
            sync2_reg    <= 2'b11;
            db_reg       <= 2'b11;
            db_prev_reg  <= 2'b11;
            period_reg   <= PERIOD_INIT;
            mask_reg     <= 2'b00;
            edge_reg     <= 2'b00;
            readdata_reg <= 32'd0;
        end else begin
            sync1_reg    <= in_port;
            sync2_reg    <= sync1_reg;
            db_reg       <= db_next;
            db_prev_reg  <= db_reg;
            period_reg   <= period_next;
            mask_reg     <= mask_next;
            edge_reg     <= edge_next;
            readdata_reg <= readdata_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(edge_reg & mask_reg);

endmodule
